// File: rtl/delay_probe_pkg.sv
// Shared types and defaults for the delay_line latency probe.
package delay_probe_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_LAUNCH,
    S_WAIT
  } state_t;

  localparam logic [7:0] DEF_PATTERN   = 8'hF0;
  localparam logic [7:0] DEF_IDLE_WORD = 8'h0F;

endpackage

// File: rtl/delay_probe_timer.sv
// Clear/enable up-counter with a terminal flag at a programmable limit.
module probe_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_count,
  output logic         o_term
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_term  = (r_count == i_limit);

endmodule

// File: rtl/delay_probe.sv
// Measures delay_line latency: flush with IDLE_WORD, launch one PATTERN, count cycles to its echo.
module delay_probe
  import delay_probe_pkg::*;
#(
  parameter int unsigned    N         = 8,
  parameter int unsigned    MAX_DELAY = 64,
  parameter logic [N-1:0]   PATTERN   = DEF_PATTERN,
  parameter logic [N-1:0]   IDLE_WORD = DEF_IDLE_WORD
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic [N-1:0]                   probe_data,
  input  logic [N-1:0]                   line_data,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout,
  output logic [$clog2(MAX_DELAY+1)-1:0] delay_out,
  output logic                           valid
);

  localparam int unsigned CW = $clog2(MAX_DELAY + 2);
  localparam int unsigned DW = $clog2(MAX_DELAY + 1);

  state_t          r_state;
  logic [N-1:0]    r_probe;
  logic            r_busy;
  logic            r_done;
  logic            r_timeout;
  logic            r_valid;
  logic [DW-1:0]   r_delay;

  logic            w_clr;
  logic            w_en;
  logic            w_term;
  logic            w_match;
  logic [CW-1:0]   w_count;

  // One timer serves both phases: it runs 0..MAX_DELAY in FLUSH, is cleared
  // on entry to LAUNCH (count 0 = delay 0), then counts k in WAIT.
  assign w_clr   = (r_state == S_IDLE) || ((r_state == S_FLUSH) && w_term);
  assign w_en    = (r_state != S_IDLE);
  assign w_match = (line_data == PATTERN);

  probe_timer #(
    .W(CW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_limit (CW'(MAX_DELAY)),
    .o_count (w_count),
    .o_term  (w_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_probe   <= IDLE_WORD;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_valid   <= 1'b0;
      r_delay   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_probe <= IDLE_WORD;
          // A start coinciding with the done/timeout pulse is dropped.
          if (start && !r_done && !r_timeout) begin
            r_state <= S_FLUSH;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_delay <= '0;
          end
        end
        S_FLUSH: begin
          if (w_term) begin
            r_state <= S_LAUNCH;
            r_probe <= PATTERN;
          end
        end
        S_LAUNCH, S_WAIT: begin
          r_probe <= IDLE_WORD;
          if (w_match) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_valid <= 1'b1;
            r_delay <= DW'(w_count);
          end else if (w_term) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_valid   <= 1'b0;
            r_delay   <= '0;
          end else begin
            r_state <= S_WAIT;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_probe <= IDLE_WORD;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign probe_data = r_probe;
  assign busy       = r_busy;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign delay_out  = r_delay;
  assign valid      = r_valid;

endmodule

// File: tb/tb_delay_probe.sv
// Bench for delay_probe: modelled delay line, cycle-level outcome model and pulse scoreboard.
module tb_delay_probe;

  localparam int unsigned N   = 8;
  localparam int unsigned MD  = 64;
  localparam logic [7:0]  PAT = 8'hF0;
  localparam logic [7:0]  IDL = 8'h0F;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] probe_data;
  logic [7:0] line_data;
  logic       busy, done, timeout, valid;
  logic [6:0] delay_out;

  always #5 clk = ~clk;

  delay_probe #(
    .N         (N),
    .MAX_DELAY (MD),
    .PATTERN   (PAT),
    .IDLE_WORD (IDL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .probe_data (probe_data),
    .line_data  (line_data),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .delay_out  (delay_out),
    .valid      (valid)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Delay line under test: lk register stages, optional tie-off and one-cycle injection.
  logic [7:0] ch [0:63];
  int  lk = 1;
  bit  tie = 1'b0;
  int  inj_off = -1;
  int  inj_cyc = -1;

  always @(posedge clk) begin
    ch[0] <= probe_data;
    for (int i = 1; i < 64; i++) ch[i] <= ch[i-1];
  end

  always_comb begin
    if (lk == 0) line_data = probe_data;
    else         line_data = ch[lk-1];
    if (tie) line_data = IDL;
    if (cyc == inj_cyc) line_data = PAT;
  end

  typedef struct {
    bit is_to;
    int dly;
    int at;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Outcome model: what the probe should report for the current measurement.
  bit m_active = 1'b0;
  int m_acc = 0, m_pulse = 0;
  bit m_res_v = 1'b0;
  int m_res_d = 0;
  bit m_hold_v = 1'b0;
  int m_hold_d = 0;
  int m_next_ok = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic accept(input int c);
    int   first;
    exp_t e;
    int   launch;
    launch  = c + 1 + (MD + 1);
    first   = tie ? -1 : lk;
    inj_cyc = (inj_off >= 0) ? launch + inj_off : -1;
    if (inj_off >= 0 && (first < 0 || inj_off < first)) first = inj_off;
    if (first < 0 || first > MD) begin
      e.is_to = 1'b1; e.dly = 0; e.at = launch + MD + 1;
    end else begin
      e.is_to = 1'b0; e.dly = first; e.at = launch + first + 1;
    end
    q.push_back(e);
    if (m_active) begin
      m_hold_v = m_res_v;
      m_hold_d = m_res_d;
    end
    m_active  = 1'b1;
    m_acc     = c;
    m_pulse   = e.at;
    m_res_v   = !e.is_to;
    m_res_d   = e.dly;
    m_next_ok = e.at + 1;
  endtask

  task automatic step(input bit s);
    @(negedge clk);
    start = s;
    if (s && !rst && cyc >= m_next_ok) accept(cyc);
  endtask

  task automatic run_to(input int t);
    while (cyc + 1 < t) step(1'b0);
  endtask

  task automatic measure(input int k, input int inj, input bit t);
    lk = k; inj_off = inj; tie = t;
    step(1'b1);
    run_to(m_pulse + 1);
  endtask

  // Monitor: per-cycle status against the model, pulses against the scoreboard.
  initial begin
    bit   eb, ev;
    int   ed;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!m_active || cyc <= m_acc) begin
        eb = 1'b0; ev = m_hold_v; ed = m_hold_d;
      end else if (cyc < m_pulse) begin
        eb = 1'b1; ev = 1'b0; ed = 0;
      end else begin
        eb = 1'b0; ev = m_res_v; ed = m_res_d;
      end
      chk("busy", busy, eb);
      chk("valid", valid, ev);
      chk("delay_out", delay_out, ed);
      while (q.size() > 0 && q[0].at < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL missing_pulse @cyc %0d: got none expected pulse at %0d", cyc, q[0].at);
        void'(q.pop_front());
      end
      if (done === 1'b1 || timeout === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pulse @cyc %0d: got done=%0b timeout=%0b expected none",
                   cyc, done, timeout);
        end else begin
          e = q.pop_front();
          chk("pulse_cycle", cyc, e.at);
          chk("pulse_is_timeout", timeout, e.is_to);
          chk("pulse_is_done", done, !e.is_to);
          chk("pulse_delay", delay_out, e.dly);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    step(1'b0);
    step(1'b0);
    chk("rst_probe_data", probe_data, IDL);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    step(1'b0);

    measure(1, -1, 1'b0);
    measure(0, -1, 1'b0);
    measure(64, -1, 1'b0);
    measure(0, -1, 1'b1);

    // Reset three cycles into WAIT, then a fresh measurement.
    lk = 5; inj_off = -1; tie = 1'b0;
    step(1'b1);
    c0 = m_acc;
    run_to(c0 + 1 + (MD + 1) + 3);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    q.delete();
    m_active = 1'b0; m_hold_v = 1'b0; m_hold_d = 0; m_next_ok = 0; inj_cyc = -1;
    step(1'b0);
    chk("rst_mid_probe_data", probe_data, IDL);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_timeout", timeout, 0);
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_delay", delay_out, 0);
    rst = 1'b0;
    step(1'b0);
    measure(5, -1, 1'b0);

    // Start held for ten cycles, then start in and right after the done cycle.
    lk = 3; inj_off = -1; tie = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1);
    run_to(m_pulse);
    step(1'b1);
    step(1'b1);
    run_to(m_pulse + 1);

    measure(7, 2, 1'b0);

    for (int i = 0; i < 5; i++) begin
      int k, inj, g;
      bit t;
      k   = int'($urandom_range(0, MD));
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, MD)) : -1;
      t   = ($urandom_range(0, 4) == 0);
      g   = int'($urandom_range(0, 3));
      for (int j = 0; j < g; j++) step(1'b0);
      measure(k, inj, t);
    end

    for (int i = 0; i < 4; i++) step(1'b0);
    chk("scoreboard_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
